serial_uart_bridge: RTL
=======================

// Module: serial_uart_bridge
// PURPOSE
//  Device-side end of the processor serial port. Converts the data_memory serial
//  handshake (serial_in/valid/ready, serial_out/rden/wren) to an 8N1 UART line pair.
//  RX path: UART deserializer -> RX FIFO -> processor reads.
//  TX path: processor writes -> TX FIFO -> UART serializer.
//  Sits at top level between the processor serial ports and the board UART pins.
// PARAMETERS
//  CLKS_PER_BIT  434  clock cycles per UART bit (50 MHz / 115200); must be >= 4.
//  FIFO_DEPTH    16   entries per FIFO; must be a power of two.
//  ADDR_W        4    log2(FIFO_DEPTH).
// PORTS
//  clock            in   1  system clock; all logic on the rising edge
//  reset            in   1  synchronous, active-high
//  proc_data_out    out  8  RX FIFO head byte; drives processor serial_in
//  proc_valid_out   out  1  RX FIFO non-empty; drives serial_valid_in
//  proc_ready_out   out  1  TX FIFO not full; drives serial_ready_in
//  proc_data_in     in   8  byte from processor serial_out
//  proc_rden_in     in   1  processor serial_rden_out; pops RX FIFO
//  proc_wren_in     in   1  processor serial_wren_out; pushes TX FIFO
//  uart_rx_in       in   1  asynchronous UART receive line, idle high
//  uart_tx_out      out  1  UART transmit line, registered, idle high
//  rx_overrun_out   out  1  sticky: received byte dropped (RX FIFO full)
//  tx_overrun_out   out  1  sticky: processor write dropped (TX FIFO full)
// BEHAVIOUR
//  Reset values: uart_tx_out=1, proc_valid_out=0, proc_ready_out=1, proc_data_out=8'h00,
//   both overrun flags 0, both FIFOs empty, both FSMs idle, synchronizer flops=1.
//   Reset asserted mid-frame aborts the frame; uart_tx_out=1 after that edge.
//  FIFOs: show-ahead, wrap-around pointers plus count. Each edge: push if requested and
//   (not full or pop in same cycle); pop if requested and not empty. Simultaneous
//   push+pop leaves the count unchanged, including when full.
//  Processor side: proc_rden_in/proc_wren_in are sampled each edge; one pop or push per
//   high cycle. rden while empty is ignored. wren while full (no same-cycle pop) drops
//   the byte and sets tx_overrun_out. proc_data_out changes on the edge after the pop.
//  RX: uart_rx_in passes a 2-flop synchronizer. FSM RX_IDLE -> RX_START -> RX_DATA -> RX_STOP.
//   RX_IDLE: a high-to-low transition on the synchronized line starts a bit counter.
//   RX_START: sample at CLKS_PER_BIT/2; if high (false start) return to RX_IDLE.
//   RX_DATA: 8 samples, one every CLKS_PER_BIT, LSB first.
//   RX_STOP: sample after CLKS_PER_BIT. If 1, push the byte (if full: drop it and set
//    rx_overrun_out). If 0 (framing error), discard. Both cases return to RX_IDLE.
//   RX_IDLE detects a new start only after the synchronized line has been high.
//   proc_valid_out rises on the edge after the stop-bit sample.
//  TX: FSM TX_IDLE -> TX_START -> TX_DATA -> TX_STOP -> TX_IDLE.
//   TX_IDLE with FIFO non-empty: pop into shift register and enter TX_START.
//   Line levels, each held CLKS_PER_BIT cycles: start=0, 8 data bits LSB first, stop=1.
//   One TX_IDLE cycle between back-to-back frames (frame period 10*CLKS_PER_BIT+1).
//   Latency: uart_tx_out goes 0 on the first edge after the edge that pushes the byte.
//  Sticky overrun flags clear only on reset.
// CONFIGURATION
//  SERIAL_BRIDGE_LOOPBACK_EN defined:
//   - adds input port loopback_in (1 bit).
//   - when loopback_in=1, the RX synchronizer input is the internal TX line and
//     uart_tx_out is held at 1.
//  Not defined: port absent; RX is always sourced from uart_rx_in.
// TESTING (CLKS_PER_BIT=4, FIFO_DEPTH=16)
//  1. Reset: hold reset 2 cycles -> uart_tx_out=1, valid=0, ready=1, both overruns 0.
//  2. RX: drive frame 8'h55 on uart_rx_in -> valid=1 and proc_data_out=8'h55 one edge
//     after the stop sample; 1-cycle rden -> valid=0 on the next edge.
//  3. TX: 1-cycle wren with 8'h41 -> uart_tx_out 0,1,0,0,0,0,0,1,0,1, each bit 4 cycles,
//     start bit beginning one edge after the push.
//  4. TX overflow: wren held 18 cycles with 8'h00..8'h11 -> 8'h00..8'h10 transmitted
//     in order; 8'h11 dropped; ready=0; tx_overrun_out=1.
//  5. RX errors: frame with stop bit 0 -> no push, valid stays 0; 1-cycle low glitch
//     -> false start, no push; 17 frames with no rden -> rx_overrun_out=1, first 16 kept.
//  6. Reset mid-frame during a TX data bit -> uart_tx_out=1 next edge, FIFOs empty,
//     no further frame.

Source files
------------

// File: rtl/serial_uart_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : serial_uart_bridge (with helper serial_uart_bridge_fifo)     |
// | Description : Bridges the processor serial handshake to an 8N1 UART pair.  |
// |               RX path : 2-flop synchronizer -> deserializer -> RX FIFO.    |
// |               TX path : TX FIFO -> serializer -> registered uart_tx_out.   |
// | Ports       : clock, reset          - clock / sync active-high reset       |
// |               proc_data_out  [7:0]  - RX FIFO head byte (0 when empty)     |
// |               proc_valid_out        - RX FIFO non-empty                    |
// |               proc_ready_out        - TX FIFO not full                     |
// |               proc_data_in   [7:0]  - byte written by the processor        |
// |               proc_rden_in          - pop RX FIFO (ignored when empty)     |
// |               proc_wren_in          - push TX FIFO                         |
// |               uart_rx_in            - asynchronous receive line, idle high |
// |               uart_tx_out           - transmit line, idle high             |
// |               rx_overrun_out        - sticky: received byte dropped        |
// |               tx_overrun_out        - sticky: processor write dropped      |
// |               loopback_in           - only with SERIAL_BRIDGE_LOOPBACK_EN: |
// |                                       RX fed from internal TX, pin held 1  |
// | Options     : `define SERIAL_BRIDGE_LOOPBACK_EN to add loopback_in.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+

// Show-ahead FIFO: o_rdata is the head entry whenever the FIFO is non-empty.
module serial_uart_bridge_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_push,
    input  logic [7:0] i_wdata,
    input  logic       i_pop,
    output logic [7:0] o_rdata,
    output logic       o_empty,
    output logic       o_full
);
    localparam logic [ADDR_W:0] c_full_count = (ADDR_W + 1)'(DEPTH);

    logic [7:0]        r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              w_do_push;
    logic              w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == c_full_count);
    assign w_do_pop  = i_pop && !o_empty;
    // A full FIFO still accepts a write when the head leaves on the same edge.
    assign w_do_push = i_push && (!o_full || w_do_pop);
    // Empty FIFO presents zero so the head output has a defined reset value.
    assign o_rdata   = o_empty ? 8'h00 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (ADDR_W + 1)'(1);
                2'b01:   r_count <= r_count - (ADDR_W + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

module serial_uart_bridge #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 16,
    parameter int ADDR_W       = 4
) (
    input  logic       clock,
    input  logic       reset,
    output logic [7:0] proc_data_out,
    output logic       proc_valid_out,
    output logic       proc_ready_out,
    input  logic [7:0] proc_data_in,
    input  logic       proc_rden_in,
    input  logic       proc_wren_in,
`ifdef SERIAL_BRIDGE_LOOPBACK_EN
    input  logic       loopback_in,
`endif
    input  logic       uart_rx_in,
    output logic       uart_tx_out,
    output logic       rx_overrun_out,
    output logic       tx_overrun_out
);
    localparam int               c_CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(CLKS_PER_BIT - 1);
    // Start bit is re-checked half a bit after the falling edge, which also
    // centres every later sample in its bit cell.
    localparam logic [c_CNT_W-1:0] c_CNT_HALF = c_CNT_W'(CLKS_PER_BIT / 2 - 1);

    localparam logic [1:0] c_RX_IDLE  = 2'd0;
    localparam logic [1:0] c_RX_START = 2'd1;
    localparam logic [1:0] c_RX_DATA  = 2'd2;
    localparam logic [1:0] c_RX_STOP  = 2'd3;

    localparam logic [1:0] c_TX_IDLE  = 2'd0;
    localparam logic [1:0] c_TX_START = 2'd1;
    localparam logic [1:0] c_TX_DATA  = 2'd2;
    localparam logic [1:0] c_TX_STOP  = 2'd3;

    // ---------------------------------------------------------------- FIFOs
    logic       w_rx_push;
    logic       w_rx_empty;
    logic       w_rx_full;
    logic [7:0] r_rx_shift;
    logic       w_tx_pop;
    logic       w_tx_empty;
    logic       w_tx_full;
    logic [7:0] w_tx_rdata;

    serial_uart_bridge_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .ADDR_W (ADDR_W)
    ) u_rx_fifo (
        .clk     (clock),
        .rst     (reset),
        .i_push  (w_rx_push),
        .i_wdata (r_rx_shift),
        .i_pop   (proc_rden_in),
        .o_rdata (proc_data_out),
        .o_empty (w_rx_empty),
        .o_full  (w_rx_full)
    );

    serial_uart_bridge_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .ADDR_W (ADDR_W)
    ) u_tx_fifo (
        .clk     (clock),
        .rst     (reset),
        .i_push  (proc_wren_in),
        .i_wdata (proc_data_in),
        .i_pop   (w_tx_pop),
        .o_rdata (w_tx_rdata),
        .o_empty (w_tx_empty),
        .o_full  (w_tx_full)
    );

    assign proc_valid_out = !w_rx_empty;
    assign proc_ready_out = !w_tx_full;

    // ------------------------------------------------------ line selection
    logic r_tx_line;
    logic w_tx_line_nxt;
    logic w_rx_src;

`ifdef SERIAL_BRIDGE_LOOPBACK_EN
    logic r_tx_pin;

    assign w_rx_src    = loopback_in ? r_tx_line : uart_rx_in;
    assign uart_tx_out = r_tx_pin;

    // Pin copy of the serializer output, forced idle while looped back.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_tx_pin <= 1'b1;
        end else begin
            r_tx_pin <= loopback_in ? 1'b1 : w_tx_line_nxt;
        end
    end
`else
    assign w_rx_src    = uart_rx_in;
    assign uart_tx_out = r_tx_line;
`endif

    // ------------------------------------------------------------ RX path
    logic               r_rx_sync1;
    logic               r_rx_sync2;
    logic               r_rx_prev;
    logic [1:0]         r_rx_state;
    logic [1:0]         w_rx_state_nxt;
    logic [c_CNT_W-1:0] r_rx_cnt;
    logic [c_CNT_W-1:0] w_rx_cnt_nxt;
    logic [2:0]         r_rx_bit;
    logic [2:0]         w_rx_bit_nxt;
    logic [7:0]         w_rx_shift_nxt;
    logic               r_rx_overrun;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rx_sync1   <= 1'b1;
            r_rx_sync2   <= 1'b1;
            r_rx_prev    <= 1'b1;
            r_rx_state   <= c_RX_IDLE;
            r_rx_cnt     <= '0;
            r_rx_bit     <= '0;
            r_rx_shift   <= '0;
            r_rx_overrun <= 1'b0;
        end else begin
            r_rx_sync1   <= w_rx_src;
            r_rx_sync2   <= r_rx_sync1;
            r_rx_prev    <= r_rx_sync2;
            r_rx_state   <= w_rx_state_nxt;
            r_rx_cnt     <= w_rx_cnt_nxt;
            r_rx_bit     <= w_rx_bit_nxt;
            r_rx_shift   <= w_rx_shift_nxt;
            // The FIFO can only refuse a completed byte when it is full and
            // the processor is not reading on the same edge.
            if (w_rx_push && w_rx_full && !proc_rden_in) begin
                r_rx_overrun <= 1'b1;
            end
        end
    end

    always_comb begin
        w_rx_state_nxt = r_rx_state;
        w_rx_cnt_nxt   = r_rx_cnt;
        w_rx_bit_nxt   = r_rx_bit;
        w_rx_shift_nxt = r_rx_shift;
        w_rx_push      = 1'b0;
        case (r_rx_state)
            c_RX_IDLE: begin
                // Falling edge only: a line stuck low after a framing error
                // must return high before another frame is accepted.
                if (r_rx_prev && !r_rx_sync2) begin
                    w_rx_state_nxt = c_RX_START;
                    w_rx_cnt_nxt   = '0;
                end
            end
            c_RX_START: begin
                if (r_rx_cnt == c_CNT_HALF) begin
                    w_rx_cnt_nxt   = '0;
                    w_rx_bit_nxt   = '0;
                    w_rx_state_nxt = r_rx_sync2 ? c_RX_IDLE : c_RX_DATA;
                end else begin
                    w_rx_cnt_nxt = r_rx_cnt + c_CNT_W'(1);
                end
            end
            c_RX_DATA: begin
                if (r_rx_cnt == c_CNT_LAST) begin
                    w_rx_cnt_nxt   = '0;
                    w_rx_shift_nxt = {r_rx_sync2, r_rx_shift[7:1]};
                    if (r_rx_bit == 3'd7) begin
                        w_rx_state_nxt = c_RX_STOP;
                    end else begin
                        w_rx_bit_nxt = r_rx_bit + 3'd1;
                    end
                end else begin
                    w_rx_cnt_nxt = r_rx_cnt + c_CNT_W'(1);
                end
            end
            c_RX_STOP: begin
                if (r_rx_cnt == c_CNT_LAST) begin
                    w_rx_cnt_nxt   = '0;
                    w_rx_state_nxt = c_RX_IDLE;
                    // A low stop bit is a framing error: the byte is discarded.
                    w_rx_push      = r_rx_sync2;
                end else begin
                    w_rx_cnt_nxt = r_rx_cnt + c_CNT_W'(1);
                end
            end
            default: begin
                w_rx_state_nxt = c_RX_IDLE;
            end
        endcase
    end

    assign rx_overrun_out = r_rx_overrun;

    // ------------------------------------------------------------ TX path
    logic [1:0]         r_tx_state;
    logic [1:0]         w_tx_state_nxt;
    logic [c_CNT_W-1:0] r_tx_cnt;
    logic [c_CNT_W-1:0] w_tx_cnt_nxt;
    logic [2:0]         r_tx_bit;
    logic [2:0]         w_tx_bit_nxt;
    logic [7:0]         r_tx_shift;
    logic [7:0]         w_tx_shift_nxt;
    logic               r_tx_overrun;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_tx_state   <= c_TX_IDLE;
            r_tx_cnt     <= '0;
            r_tx_bit     <= '0;
            r_tx_shift   <= '0;
            r_tx_line    <= 1'b1;
            r_tx_overrun <= 1'b0;
        end else begin
            r_tx_state   <= w_tx_state_nxt;
            r_tx_cnt     <= w_tx_cnt_nxt;
            r_tx_bit     <= w_tx_bit_nxt;
            r_tx_shift   <= w_tx_shift_nxt;
            r_tx_line    <= w_tx_line_nxt;
            if (proc_wren_in && w_tx_full && !w_tx_pop) begin
                r_tx_overrun <= 1'b1;
            end
        end
    end

    // The line level is computed alongside the state so each new level is
    // registered on the same edge that enters its state.
    always_comb begin
        w_tx_state_nxt = r_tx_state;
        w_tx_cnt_nxt   = r_tx_cnt;
        w_tx_bit_nxt   = r_tx_bit;
        w_tx_shift_nxt = r_tx_shift;
        w_tx_line_nxt  = r_tx_line;
        w_tx_pop       = 1'b0;
        case (r_tx_state)
            c_TX_IDLE: begin
                w_tx_line_nxt = 1'b1;
                if (!w_tx_empty) begin
                    w_tx_pop       = 1'b1;
                    w_tx_shift_nxt = w_tx_rdata;
                    w_tx_cnt_nxt   = '0;
                    w_tx_bit_nxt   = '0;
                    w_tx_line_nxt  = 1'b0;
                    w_tx_state_nxt = c_TX_START;
                end
            end
            c_TX_START: begin
                if (r_tx_cnt == c_CNT_LAST) begin
                    w_tx_cnt_nxt   = '0;
                    w_tx_line_nxt  = r_tx_shift[0];
                    w_tx_state_nxt = c_TX_DATA;
                end else begin
                    w_tx_cnt_nxt = r_tx_cnt + c_CNT_W'(1);
                end
            end
            c_TX_DATA: begin
                if (r_tx_cnt == c_CNT_LAST) begin
                    w_tx_cnt_nxt = '0;
                    if (r_tx_bit == 3'd7) begin
                        w_tx_line_nxt  = 1'b1;
                        w_tx_state_nxt = c_TX_STOP;
                    end else begin
                        w_tx_bit_nxt   = r_tx_bit + 3'd1;
                        w_tx_shift_nxt = {1'b1, r_tx_shift[7:1]};
                        w_tx_line_nxt  = r_tx_shift[1];
                    end
                end else begin
                    w_tx_cnt_nxt = r_tx_cnt + c_CNT_W'(1);
                end
            end
            c_TX_STOP: begin
                // Returning through TX_IDLE gives the one idle cycle between
                // back-to-back frames.
                if (r_tx_cnt == c_CNT_LAST) begin
                    w_tx_cnt_nxt   = '0;
                    w_tx_state_nxt = c_TX_IDLE;
                end else begin
                    w_tx_cnt_nxt = r_tx_cnt + c_CNT_W'(1);
                end
            end
            default: begin
                w_tx_state_nxt = c_TX_IDLE;
                w_tx_line_nxt  = 1'b1;
            end
        endcase
    end

    assign tx_overrun_out = r_tx_overrun;
endmodule
`default_nettype wire
